// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 holds the operands, S2 holds the computed result and flags.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_f,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [3:0]       out_flags,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int M    = WIDTH - 1;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ANDN = 4'h4;
    localparam logic [3:0] OP_ORN  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;

    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [3:0]       s1_f_q, s1_f_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] s2_y_q, s2_y_d;
    logic [3:0]       s2_flags_q, s2_flags_d;
    logic             s2_err_q, s2_err_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s2_load;
    logic             s1_load;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SH_W-1:0]  sh;
    logic             v_add;
    logic             v_sub;
    logic [WIDTH-1:0] y_c;
    logic             c_c;
    logic             v_c;
    logic             err_c;

    assign s2_load  = !s2_v_q || out_ready;
    assign s1_load  = !s1_v_q || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        sum   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        diff  = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        sh    = s1_b_q[SH_W-1:0];
        v_add = (s1_a_q[M] == s1_b_q[M]) && (sum[M] != s1_a_q[M]);
        v_sub = (s1_a_q[M] != s1_b_q[M]) && (diff[M] != s1_a_q[M]);
        y_c   = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        err_c = 1'b0;
        case (s1_f_q)
            OP_AND:  y_c = s1_a_q & s1_b_q;
            OP_OR:   y_c = s1_a_q | s1_b_q;
            OP_ADD: begin
                y_c = sum[M:0];
                c_c = sum[WIDTH];
                v_c = v_add;
            end
            OP_XOR:  y_c = s1_a_q ^ s1_b_q;
            OP_ANDN: y_c = s1_a_q & ~s1_b_q;
            OP_ORN:  y_c = s1_a_q | ~s1_b_q;
            OP_SUB: begin
                y_c = diff[M:0];
                c_c = ~diff[WIDTH];
                v_c = v_sub;
            end
            // signed less-than is sign of A-B corrected by overflow
            OP_SLT:  y_c = {{(WIDTH-1){1'b0}}, diff[M] ^ v_sub};
            OP_SLL:  y_c = s1_a_q << sh;
            OP_SRL:  y_c = s1_a_q >> sh;
            OP_SRA:  y_c = $unsigned($signed(s1_a_q) >>> sh);
            OP_NOR:  y_c = ~(s1_a_q | s1_b_q);
            default: err_c = 1'b1;
        endcase
    end

    always_comb begin
        s1_v_d   = s1_v_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_f_d   = s1_f_q;
        s1_tag_d = s1_tag_q;
        if (s1_load) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_a_d   = in_a;
                s1_b_d   = in_b;
                s1_f_d   = in_f;
                s1_tag_d = in_tag;
            end
        end
    end

    always_comb begin
        s2_v_d     = s2_v_q;
        s2_y_d     = s2_y_q;
        s2_flags_d = s2_flags_q;
        s2_err_d   = s2_err_q;
        s2_tag_d   = s2_tag_q;
        if (s2_load) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_y_d     = y_c;
                s2_flags_d = {y_c[M], y_c == '0, c_c, v_c};
                s2_err_d   = err_c;
                s2_tag_d   = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v_q     <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_f_q     <= '0;
            s1_tag_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_y_q     <= '0;
            s2_flags_q <= '0;
            s2_err_q   <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_f_q     <= s1_f_d;
            s1_tag_q   <= s1_tag_d;
            s2_v_q     <= s2_v_d;
            s2_y_q     <= s2_y_d;
            s2_flags_q <= s2_flags_d;
            s2_err_q   <= s2_err_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_y     = s2_y_q;
    assign out_flags = s2_flags_q;
    assign out_err   = s2_err_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=32, TAG_W=4).
// Outputs are sampled 1ns after each rising edge.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_f;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_flags;
    logic        out_err;
    logic [3:0]  out_tag;

    int errors = 0;
    int checks = 0;

    alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_f      (in_f),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_flags (out_flags),
        .out_err   (out_err),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t);
        in_valid = 1'b1;
        in_f     = f;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_f      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y", out_y, 32'd0);
        chk("rst_flags", {28'd0, out_flags}, 32'd0);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        chk("rst_tag", {28'd0, out_tag}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD overflow, two-edge latency
        drive(4'h2, 32'h7FFFFFFF, 32'h00000001, 4'd3);
        step();
        in_valid = 1'b0;
        chk("add_lat1_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_y", out_y, 32'h80000000);
        chk("add_flags", {28'd0, out_flags}, 32'h9);
        chk("add_err", {31'd0, out_err}, 32'd0);
        chk("add_tag", {28'd0, out_tag}, 32'd3);

        // SUB equal then SLT back-to-back
        drive(4'h6, 32'h5, 32'h5, 4'd4);
        step();
        drive(4'h7, 32'hFFFFFFFF, 32'h1, 4'd5);
        step();
        in_valid = 1'b0;
        chk("sub_y", out_y, 32'h0);
        chk("sub_flags", {28'd0, out_flags}, 32'h6);
        step();
        chk("slt_y", out_y, 32'h1);
        chk("slt_flags", {28'd0, out_flags}, 32'h0);
        chk("slt_tag", {28'd0, out_tag}, 32'd5);

        // Shifts: SRA sign fill, SLL max amount, SRL amount 0
        drive(4'hA, 32'h80000000, 32'h00000024, 4'd6);
        step();
        drive(4'h8, 32'h00000001, 32'h0000001F, 4'd7);
        step();
        drive(4'h9, 32'h12345678, 32'h00000020, 4'd8);
        chk("sra_y", out_y, 32'hF8000000);
        chk("sra_flags", {28'd0, out_flags}, 32'h8);
        step();
        in_valid = 1'b0;
        chk("sll_y", out_y, 32'h80000000);
        step();
        chk("srl0_y", out_y, 32'h12345678);

        // Reserved opcode
        drive(4'hF, 32'h12345678, 32'h0, 4'd9);
        step();
        in_valid = 1'b0;
        step();
        chk("rsv_y", out_y, 32'h0);
        chk("rsv_err", {31'd0, out_err}, 32'd1);
        chk("rsv_flags", {28'd0, out_flags}, 32'h4);
        step();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: three ADDs while consumer stalls
        out_ready = 1'b0;
        drive(4'h2, 32'd1, 32'd16, 4'd1);
        step();
        chk("bp_ready1", {31'd0, in_ready}, 32'd1);
        drive(4'h2, 32'd2, 32'd16, 4'd2);
        step();
        chk("bp_ready2", {31'd0, in_ready}, 32'd0);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        drive(4'h2, 32'd3, 32'd16, 4'd3);
        step();
        chk("bp_hold_tag", {28'd0, out_tag}, 32'd1);
        chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("bp_stable_y", out_y, 32'd17);
        chk("bp_stable_tag", {28'd0, out_tag}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_tag2", {28'd0, out_tag}, 32'd2);
        chk("bp_y2", out_y, 32'd18);
        step();
        chk("bp_tag3", {28'd0, out_tag}, 32'd3);
        chk("bp_y3", out_y, 32'd19);
        chk("bp_valid3", {31'd0, out_valid}, 32'd1);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset with two operations in flight
        out_ready = 1'b0;
        drive(4'h2, 32'd100, 32'd1, 4'd10);
        step();
        drive(4'h3, 32'hFF, 32'h0F, 4'd11);
        step();
        in_valid = 1'b0;
        reset    = 1'b0;
        step();
        reset = 1'b1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_y", out_y, 32'd0);
        chk("mrst_flags", {28'd0, out_flags}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        drive(4'h2, 32'd1, 32'd1, 4'd12);
        step();
        in_valid = 1'b0;
        step();
        chk("post_valid", {31'd0, out_valid}, 32'd1);
        chk("post_y", out_y, 32'd2);
        chk("post_flags", {28'd0, out_flags}, 32'd0);
        chk("post_tag", {28'd0, out_tag}, 32'd12);
        step();
        chk("post_empty", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational 32-bit ALU.
- Two-stage registered pipeline with valid/ready handshakes on both sides, so it can sit between an operand-fetch stage and a writeback stage that may stall.
- Adds the following beyond the combinational ALU:
  - width generalisation;
  - shift ops;
  - a full N/Z/C/V flag set;
  - a reserved-op error flag;
  - a tag passthrough so the consumer can match results to requests.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, minimum 8.
- TAG_W, 4, width of the request tag carried alongside each operation.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B; the low log2(WIDTH) bits are the shift amount for shift ops.
- in_f  input  4  opcode.
- in_tag  input  TAG_W  request tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_y  output  WIDTH  result.
- out_flags  output  4  flags in the order {N, Z, C, V}.
- out_err  output  1  opcode was reserved.
- out_tag  output  TAG_W  tag of the request this result belongs to.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 XOR.
  - 4 A&~B, 5 A|~B, 6 SUB (A-B).
  - 7 SLT (signed; y = 1 or 0).
  - 8 SLL, 9 SRL, A SRA, B NOR.
  - C-F reserved: y = 0, err = 1.
- Flags:
  - N = y[WIDTH-1]; Z = (y == 0).
  - C: ADD gives the carry-out of bit WIDTH-1. SUB gives NOT borrow (1 when A >= B unsigned). All other ops give 0.
  - V: signed overflow for ADD/SUB only; 0 otherwise.
  - SLT computes A-B internally but reports C = 0, V = 0.
- Pipeline:
  - Stage 1 (S1) registers the operands, opcode and tag.
  - Stage 2 (S2) registers the computed y, flags, err and tag, and drives the out_* ports directly from registers.
- Advance rule:
  - S2 loads when S2 is empty or out_ready = 1.
  - S1 loads when S1 is empty or S1 is moving into S2.
  - in_ready = !s1_v | !s2_v | out_ready (combinational, no bubbles).
- Acceptance:
  - A request transfers on a rising edge with in_valid & in_ready.
  - A result transfers on a rising edge with out_valid & out_ready.
- Latency: a request accepted at edge t has out_valid = 1 after edge t+1. Throughput is one operation per cycle while out_ready = 1.
- Stall:
  - While out_valid = 1 and out_ready = 0, out_y, out_flags, out_err and out_tag hold stable.
  - With both stages full and out_ready = 0, in_ready = 0. The pipeline holds at most 2 operations.
- Simultaneous accept and drain: when S2 is emptied and S1 refilled on the same edge, no operation is lost or duplicated, and results leave in acceptance order.
- in_* inputs are ignored when in_valid = 0 or in_ready = 0; the held stage contents must not change.
- Reset (reset = 0 at a rising edge):
  - s1_v and s2_v are cleared, and all in-flight operations are discarded.
  - out_valid = 0, out_y = 0, out_flags = 4'b0000, out_err = 0, out_tag = 0.
  - in_ready = 1 from the first cycle after reset is released.
- Shifts: the amount uses b[log2(WIDTH)-1:0] only, and the upper bits of b are ignored. SRA sign-fills. A shift amount of 0 passes A through unchanged.

Test Plan:
- All tests use WIDTH = 32.
- ADD, a = 7FFFFFFF, b = 00000001, tag 3 -> after 2 edges out_y = 80000000, flags = 4'b1001, err = 0, tag = 3.
- SUB, a = 00000005, b = 00000005 -> out_y = 00000000, flags = 4'b0110. Then SLT with a = FFFFFFFF, b = 00000001 -> out_y = 00000001, flags = 4'b0000.
- SRA, a = 80000000, b = 00000024 (amount 4) -> out_y = F8000000, flags = 4'b1000. Then SLL with a = 00000001, b = 0000001F -> out_y = 80000000.
- Backpressure:
  - Stimulus: out_ready = 0, then 3 back-to-back ADD requests with tags 1, 2, 3.
  - in_ready drops after the 2nd is accepted, and tag 3 is held at the input.
  - Raising out_ready yields results with tags 1, 2, 3 in order on consecutive cycles, with none lost or duplicated.
- Reserved opcode: f = F, a = 12345678 -> out_y = 00000000, err = 1, flags = 4'b0100.
- Reset mid-operation:
  - Stimulus: 2 ops in flight with out_ready = 0, then reset = 0 for 1 cycle.
  - Next cycle: out_valid = 0, out_y = 0, flags = 0, in_ready = 1.
  - A following ADD of 1 + 1 returns 00000002 with flags 4'b0000.
